// File: rtl/seq_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : seq_muldiv
//  Description : Iterative signed/unsigned multiply/divide unit. Radix-2 Booth
//                multiply and restoring divide, one result bit per cycle,
//                start/done handshake with busy and divide-by-zero flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    // Booth: accumulator (high half); divide: partial remainder
    logic [WIDTH:0]       acc_q, acc_d;
    // Booth: multiplier shifting into product low half; divide: dividend -> quotient
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 qm1_q, qm1_d;
    // Booth: extended multiplicand; divide: divisor magnitude
    logic [WIDTH:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]     orig_a_q, orig_a_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic                 bmsb_q, bmsb_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 dbz_q, dbz_d;

    // Operand preparation at accept time
    logic                 is_signed;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & operand_a[WIDTH-1];
    assign b_neg     = is_signed & operand_b[WIDTH-1];
    assign a_mag     = a_neg ? -operand_a : operand_a;
    assign b_mag     = b_neg ? -operand_b : operand_b;

    // Per-iteration datapath terms
    logic [WIDTH:0]       booth_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]     q_fix, r_fix;

    // Booth add/sub term, restoring-divide trial subtract and final fix-ups
    always_comb begin
        case ({lo_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcand_q;
            2'b10:   booth_sum = acc_q - mcand_q;
            default: booth_sum = acc_q;
        endcase
        div_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_ge    = (div_shift >= mcand_q);
        // The Booth loop treats the multiplier as signed; an unsigned multiplier
        // with its MSB set needs multiplicand*2^WIDTH added back.
        mul_res   = {acc_q[WIDTH-1:0], lo_q}
                  + (bmsb_q ? {mcand_q[WIDTH-1:0], {WIDTH{1'b0}}} : {2*WIDTH{1'b0}});
        q_fix     = qneg_q ? -lo_q : lo_q;
        r_fix     = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        mcand_d  = mcand_q;
        orig_a_d = orig_a_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        bmsb_d   = bmsb_q;
        result_d = result_q;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d  = S_RUN;
                    op_d     = op;
                    cnt_d    = CW'(WIDTH);
                    acc_d    = '0;
                    qm1_d    = 1'b0;
                    orig_a_d = operand_a;
                    result_d = '0;
                    dbz_d    = 1'b0;
                    if (op[1]) begin
                        lo_d    = a_mag;
                        mcand_d = {1'b0, b_mag};
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        bmsb_d  = 1'b0;
                    end else begin
                        lo_d    = operand_b;
                        mcand_d = {a_neg, operand_a};
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        bmsb_d  = op[0] & operand_b[WIDTH-1];
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q[1]) begin
                    acc_d = div_ge ? (div_shift - mcand_q) : div_shift;
                    lo_d  = {lo_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
                    qm1_d = lo_q[0];
                end
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                if (!op_q[1]) begin
                    result_d = mul_res;
                    dbz_d    = 1'b0;
                end else if (mcand_q == '0) begin
                    result_d = {orig_a_q, {WIDTH{1'b1}}};
                    dbz_d    = 1'b1;
                end else begin
                    result_d = {r_fix, q_fix};
                    dbz_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            mcand_q  <= '0;
            orig_a_q <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            mcand_q  <= mcand_d;
            orig_a_q <= orig_a_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            bmsb_q   <= bmsb_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign result      = result_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_muldiv
//  Description : Self-checking bench for seq_muldiv at WIDTH 8, 16 and 32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  op;
    logic [31:0] opa, opb;
    logic        start8, start16, start32;
    logic [15:0] res8;
    logic [31:0] res16;
    logic [63:0] res32;
    logic        busy8, busy16, busy32;
    logic        done8, done16, done32;
    logic        dbz8, dbz16, dbz32;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_muldiv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op),
        .operand_a(opa[7:0]), .operand_b(opb[7:0]),
        .result(res8), .busy(busy8), .done(done8), .div_by_zero(dbz8));

    seq_muldiv #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op),
        .operand_a(opa[15:0]), .operand_b(opb[15:0]),
        .result(res16), .busy(busy16), .done(done16), .div_by_zero(dbz16));

    seq_muldiv #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op),
        .operand_a(opa), .operand_b(opb),
        .result(res32), .busy(busy32), .done(done32), .div_by_zero(dbz32));

    function automatic logic [63:0] get_res(int w);
        case (w)
            8:       return {48'd0, res8};
            16:      return {32'd0, res16};
            default: return res32;
        endcase
    endfunction

    function automatic logic get_done(int w);
        case (w)
            8:       return done8;
            16:      return done16;
            default: return done32;
        endcase
    endfunction

    function automatic logic get_busy(int w);
        case (w)
            8:       return busy8;
            16:      return busy16;
            default: return busy32;
        endcase
    endfunction

    function automatic logic get_dbz(int w);
        case (w)
            8:       return dbz8;
            16:      return dbz16;
            default: return dbz32;
        endcase
    endfunction

    task automatic set_start(int w, logic v);
        case (w)
            8:       start8  = v;
            16:      start16 = v;
            default: start32 = v;
        endcase
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic with plain integer operators
    function automatic void model(int w, logic [1:0] o, logic [31:0] a, logic [31:0] b,
                                  output logic [63:0] res, output logic dbz);
        longint unsigned mask   = (64'd1 << w) - 64'd1;
        longint unsigned mask2  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        longint unsigned au     = longint'(a) & mask;
        longint unsigned bu     = longint'(b) & mask;
        longint          sa     = longint'(au);
        longint          sb     = longint'(bu);
        longint          q, r;
        longint          minv;
        if (au[w-1]) sa = sa - (longint'(1) << w);
        if (bu[w-1]) sb = sb - (longint'(1) << w);
        minv = -(longint'(1) << (w - 1));
        dbz = 1'b0;
        q = 0;
        r = 0;
        if (!o[1]) begin
            if (o[0]) res = (au * bu) & mask2;
            else      res = longint'(sa * sb) & mask2;
        end else begin
            if (bu == 0) begin
                q = longint'(mask);
                r = longint'(au);
                dbz = 1'b1;
            end else if (!o[0]) begin
                if (sa == minv && sb == -1) begin
                    q = minv;
                    r = 0;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
            end else begin
                q = longint'(au / bu);
                r = longint'(au % bu);
            end
            res = ((longint'(r) & mask) << w) | (longint'(q) & mask);
        end
    endfunction

    task automatic issue(int w, logic [1:0] o, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        op  = o;
        opa = a;
        opb = b;
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        set_start(w, 1'b0);
    endtask

    // Count edges until done rises; a missing done shows up as a latency miscompare
    task automatic wait_done(int w, int exp_lat, string tag);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!get_done(w) && n < exp_lat + 4);
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    endtask

    task automatic run(int w, logic [1:0] o, logic [31:0] a, logic [31:0] b,
                       logic [63:0] exp, logic exp_dbz, string tag);
        issue(w, o, a, b);
        wait_done(w, w + 1, tag);
        chk({tag, " result"}, get_res(w), exp);
        chk({tag, " dbz"}, 64'(get_dbz(w)), 64'(exp_dbz));
        chk({tag, " busy at done"}, 64'(get_busy(w)), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, " done pulse"}, 64'(get_done(w)), 64'd0);
        chk({tag, " result held"}, get_res(w), exp);
        chk({tag, " dbz held"}, 64'(get_dbz(w)), 64'(exp_dbz));
    endtask

    initial begin
        logic [63:0] exp;
        logic        exp_dbz;
        int          pulses;
        int          widths[3] = '{8, 16, 32};

        rst = 1'b1;
        op = 2'b00;
        opa = '0;
        opb = '0;
        start8 = 1'b0;
        start16 = 1'b0;
        start32 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", get_res(8), 64'd0);
        chk("reset busy", 64'(busy8), 64'd0);
        chk("reset done", 64'(done8), 64'd0);
        chk("reset dbz", 64'(dbz8), 64'd0);
        chk("reset result32", res32, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases at WIDTH=8
        run(8, 2'b00, 32'h80, 32'h80, 64'h4000, 1'b0, "smul min*min");
        run(8, 2'b00, 32'hCE, 32'h32, 64'hF63C, 1'b0, "smul -50*50");
        run(8, 2'b01, 32'hFF, 32'hFF, 64'hFE01, 1'b0, "umul ff*ff");
        run(8, 2'b00, 32'hFF, 32'hFF, 64'h0001, 1'b0, "smul -1*-1");
        run(8, 2'b10, 32'hF9, 32'h02, 64'hFFFD, 1'b0, "sdiv -7/2");
        run(8, 2'b11, 32'd200, 32'd7, 64'h041C, 1'b0, "udiv 200/7");
        run(8, 2'b10, 32'h80, 32'hFF, 64'h0080, 1'b0, "sdiv min/-1");
        run(8, 2'b11, 32'h2A, 32'h00, 64'h2AFF, 1'b1, "udiv by zero");
        run(8, 2'b10, 32'hF9, 32'h00, 64'hF9FF, 1'b1, "sdiv by zero");

        // start while busy is ignored; start during DONE is accepted
        issue(8, 2'b01, 32'h10, 32'h03);
        repeat (3) @(posedge clk);
        #1;
        op = 2'b00;
        opa = 32'h77;
        opb = 32'h55;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done(8, 5, "busy start");
        chk("busy start result", get_res(8), 64'h0030);
        op = 2'b11;
        opa = 32'd100;
        opb = 32'd9;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        chk("b2b done pulse", 64'(done8), 64'd0);
        chk("b2b busy", 64'(busy8), 64'd1);
        wait_done(8, 9, "b2b");
        chk("b2b result", get_res(8), 64'h010B);
        chk("b2b dbz", 64'(dbz8), 64'd0);

        // Reset mid-RUN abandons the operation
        issue(8, 2'b00, 32'h12, 32'h34);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst busy", 64'(busy8), 64'd0);
        chk("midrst result", get_res(8), 64'd0);
        chk("midrst done", 64'(done8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done8) pulses++;
        end
        chk("midrst no done", 64'(pulses), 64'd0);
        run(8, 2'b00, 32'h12, 32'h34, 64'h03A8, 1'b0, "after reset");

        // Random regression against the reference model
        foreach (widths[k]) begin
            for (int i = 0; i < 15; i++) begin
                logic [1:0]  ro;
                logic [31:0] ra, rb;
                ro = 2'($urandom_range(0, 3));
                ra = $urandom;
                rb = $urandom;
                if ($urandom_range(0, 7) == 0) rb = 32'd0;
                model(widths[k], ro, ra, rb, exp, exp_dbz);
                run(widths[k], ro, ra, rb, exp, exp_dbz,
                    $sformatf("rand w%0d op%0d #%0d", widths[k], ro, i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_muldiv.md
Name: seq_muldiv

Overview:
Parametrised iterative multiply/divide unit, signed and unsigned, one result bit per cycle. It succeeds the fixed 8-bit sequential Booth multiplier and adds operand width, a divide mode, and an unsigned mode. It keeps the start/done handshake style and adds a busy output and a divide-by-zero flag. It sits beside the ALU datapath as its multi-cycle arithmetic engine.

Parameters:
WIDTH, 8, operand width in bits (legal range 4..32); result is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  2  00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div; captured with start
operand_a  input  WIDTH  multiplicand / dividend; captured with start
operand_b  input  WIDTH  multiplier / divisor; captured with start
result  output  2*WIDTH  mul: full product; div: {remainder, quotient}
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result valid
div_by_zero  output  1  set with done when a div op had operand_b=0; held until next accept

Behaviour:
- Reset: every register (and every output) goes to 0: result=0, busy=0, done=0, div_by_zero=0, state=IDLE. Reset wins over start in the same cycle. Reset mid-operation abandons the operation and produces no done.
- States: IDLE, RUN, FIX, DONE.
- Accept: on edge E0, if start=1 and state is IDLE or DONE:
  - capture op, operand_a, operand_b;
  - load the iteration counter with WIDTH;
  - state becomes RUN, busy becomes 1, done becomes 0.
- start while busy=1 is ignored. It has no effect and is not queued.
- RUN: one iteration per cycle on edges E1..E(WIDTH); counter decrements.
  - Mul: radix-2 Booth add/sub/arith-shift on a (WIDTH+1)-bit accumulator. Unsigned ops zero-extend the operands by one bit.
  - Div: restoring shift-subtract on operand magnitudes. Signed ops take absolute values at accept.
  - After the last iteration, state becomes FIX.
- FIX, edge E(WIDTH+1):
  - Apply sign correction.
  - Register result.
  - Set done=1, busy=0, state=DONE.
- Latency: exactly WIDTH+1 edges from the accept edge to done rising. This is independent of operand values, including div-by-zero.
- DONE lasts one cycle. done then clears: state goes to IDLE, or to RUN if start is accepted in that cycle (back-to-back issue, done pulse still exactly one cycle). result and div_by_zero hold until the next accept edge. They hold through IDLE.
- Arithmetic rules:
  - Signed mul: result = two's-complement product, exact for all inputs including MIN*MIN.
  - Unsigned mul: exact unsigned product.
  - Div, quotient: truncates toward zero.
  - Div, remainder: has the sign of the dividend, and quotient*divisor + remainder = dividend.
  - Divide by zero: quotient = all ones and remainder = operand_a, for both signed and unsigned. div_by_zero=1.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0, div_by_zero=0.
- op values are all defined. No illegal-op state.

Test Plan:
1. WIDTH=8, op=00, a=0x80, b=0x80 -> done exactly 9 edges after accept; result=0x4000 (16384). Then a=0xCE (-50), b=0x32 (50) -> result=0xF63C (-2500).
2. WIDTH=8, op=01, a=0xFF, b=0xFF -> result=0xFE01 (65025). Same operands with op=00 -> result=0x0001.
3. WIDTH=8, op=10, a=0xF9 (-7), b=0x02 -> quotient=0xFD (-3), remainder=0xFF (-1), so result=0xFFFD. Then op=11, a=200, b=7 -> quotient=28, remainder=4, so result=0x041C.
4. WIDTH=8, op=10, a=0x80, b=0xFF -> result=0x0080, div_by_zero=0. Then op=11, a=0x2A, b=0 -> result=0x2AFF, div_by_zero=1, latency still 9 edges.
5. Assert start with new operands while busy -> ignored; first result is unchanged and done pulses once. Assert start during the DONE cycle -> accepted; the second done arrives 9 edges later.
6. Assert rst for one cycle mid-RUN -> next edge gives busy=0, result=0; no done follows. A fresh start afterwards completes correctly.
7. Regress with WIDTH=16 and WIDTH=32 on random operands against a behavioural model, with latency checked as WIDTH+1 edges.
